// File: rtl/npc_ras.sv
// ----------------------------------------------------------------------------
// npc_ras
//
// Next-PC unit for the PPC pipeline with a circular return-address stack.
//
// Purpose:
//   Resolves the B / BC / BCCTR / BCLR / INT / RFI targets combinationally and
//   produces the CTR and LR write-back values. A RAS is pushed on every taken
//   linking branch and popped on every taken BCLR. It gives the fetch stage a
//   BCLR target prediction and a registered "last prediction was wrong" flag.
//
// Bit numbering:
//   The ISA documents fields big-endian (bit 0 = MSB). The ports are declared
//   descending, so big-endian bit k of an N-bit field sits at index N-1-k.
//   For example, BO[0] is Imm26[25], and CR bit BI is CRrd[31-BI].
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   op_valid, stall  the RAS/CTR/LR are updated only when op_valid & ~stall
//   Op               0 PLUS4, 1 B, 2 BC, 3 BCCTR, 4 BCLR, 5 INT, 6 RFI, 7 PLUS4
//   Imm26            instruction bits [6:31]: BO, BI, LI/BD, AA, LK
//   PC, PCB          fetch PC and branch-instruction PC
//   CRrd, CTRrd, LRrd, SRR0rd   architectural register read values
//   NPC              resolved next PC (combinational)
//   CTRwd/ctr_we     CTR write-back
//   LRwd/lr_we       LR write-back (PCB+4)
//   ras_pred         top-of-stack entry (combinational from state)
//   ras_pred_valid   stack non-empty
//   ras_mispred      registered; the last taken BCLR disagreed with ras_pred
//   ras_count        occupancy, 0..RAS_DEPTH
// ----------------------------------------------------------------------------
module npc_ras #(
    parameter int                  PC_WIDTH  = 32,
    parameter int                  RAS_DEPTH = 8,
    parameter int                  RAS_PTR_W = 3,
    parameter logic [PC_WIDTH-1:0] INT_ENTRY = 32'h0000_0500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic                  stall,
    input  logic [2:0]            Op,
    input  logic [25:0]           Imm26,
    input  logic [PC_WIDTH-1:0]   PC,
    input  logic [PC_WIDTH-1:0]   PCB,
    input  logic [31:0]           CRrd,
    input  logic [PC_WIDTH-1:0]   CTRrd,
    input  logic [PC_WIDTH-1:0]   LRrd,
    input  logic [PC_WIDTH-1:0]   SRR0rd,
    output logic [PC_WIDTH-1:0]   NPC,
    output logic [PC_WIDTH-1:0]   CTRwd,
    output logic                  ctr_we,
    output logic [PC_WIDTH-1:0]   LRwd,
    output logic                  lr_we,
    output logic [PC_WIDTH-1:0]   ras_pred,
    output logic                  ras_pred_valid,
    output logic                  ras_mispred,
    output logic [RAS_PTR_W:0]    ras_count
);

    localparam logic [2:0] OP_PLUS4 = 3'd0;
    localparam logic [2:0] OP_B     = 3'd1;
    localparam logic [2:0] OP_BC    = 3'd2;
    localparam logic [2:0] OP_BCCTR = 3'd3;
    localparam logic [2:0] OP_BCLR  = 3'd4;
    localparam logic [2:0] OP_INT   = 3'd5;
    localparam logic [2:0] OP_RFI   = 3'd6;

    localparam logic [RAS_PTR_W:0] CNT_FULL = (RAS_PTR_W+1)'(RAS_DEPTH);

    // ------------------------------------------------------------------
    // Field decode (w_bo[4] is BO[0], w_bo[0] is BO[4])
    // ------------------------------------------------------------------
    logic [4:0]          w_bo;
    logic [4:0]          w_bi;
    logic [23:0]         w_li;
    logic [13:0]         w_bd;
    logic                w_aa;
    logic                w_lk;
    logic [PC_WIDTH-1:0] w_ext_li;
    logic [PC_WIDTH-1:0] w_ext_bd;
    logic [PC_WIDTH-1:0] w_base;
    logic [PC_WIDTH-1:0] w_pcb4;
    logic [PC_WIDTH-1:0] w_ctrwd;
    logic                w_cr_bit;
    logic                w_ctr_ok;
    logic                w_cond_ok;
    logic                w_taken;
    logic                w_upd;

    assign w_bo     = Imm26[25:21];
    assign w_bi     = Imm26[20:16];
    assign w_li     = Imm26[25:2];
    assign w_bd     = Imm26[15:2];
    assign w_aa     = Imm26[1];
    assign w_lk     = Imm26[0];

    assign w_ext_li = {{(PC_WIDTH-26){w_li[23]}}, w_li, 2'b00};
    assign w_ext_bd = {{(PC_WIDTH-16){w_bd[13]}}, w_bd, 2'b00};
    assign w_base   = w_aa ? '0 : PCB;
    assign w_pcb4   = PCB + PC_WIDTH'(4);

    // BO[2]=1 means "do not touch CTR"; the CTR test uses the decremented value.
    assign w_ctrwd   = w_bo[2] ? CTRrd : (CTRrd - PC_WIDTH'(1));
    assign w_ctr_ok  = w_bo[2] | ((w_ctrwd != '0) ^ w_bo[1]);
    assign w_cr_bit  = CRrd[5'd31 - w_bi];
    assign w_cond_ok = w_bo[4] | (w_cr_bit == w_bo[3]);

    // ------------------------------------------------------------------
    // Target selection
    // ------------------------------------------------------------------
    always_comb begin
        NPC     = PC + PC_WIDTH'(4);
        w_taken = 1'b0;
        case (Op)
            OP_B: begin
                NPC     = w_base + w_ext_li;
                w_taken = 1'b1;
            end
            OP_BC: begin
                w_taken = w_ctr_ok & w_cond_ok;
                NPC     = w_taken ? (w_base + w_ext_bd) : w_pcb4;
            end
            OP_BCCTR: begin
                w_taken = w_cond_ok;
                NPC     = w_taken ? {CTRrd[PC_WIDTH-1:2], 2'b00} : w_pcb4;
            end
            OP_BCLR: begin
                w_taken = w_ctr_ok & w_cond_ok;
                NPC     = w_taken ? {LRrd[PC_WIDTH-1:2], 2'b00} : w_pcb4;
            end
            OP_INT:   NPC = INT_ENTRY;
            OP_RFI:   NPC = SRR0rd;
            default:  NPC = PC + PC_WIDTH'(4);
        endcase
    end

    // ------------------------------------------------------------------
    // Architectural write-back
    // ------------------------------------------------------------------
    assign w_upd  = op_valid & ~stall;
    assign CTRwd  = w_ctrwd;
    assign LRwd   = w_pcb4;
    assign ctr_we = w_upd & ((Op == OP_BC) | (Op == OP_BCLR)) & ~w_bo[2];
    // LR is written by any linking branch, taken or not.
    assign lr_we  = w_upd & w_lk &
                    ((Op == OP_B) | (Op == OP_BC) | (Op == OP_BCCTR) | (Op == OP_BCLR));

    // ------------------------------------------------------------------
    // Return-address stack
    // ------------------------------------------------------------------
    logic [PC_WIDTH-1:0]  r_ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_tp;
    logic [RAS_PTR_W:0]   r_cnt;
    logic                 r_mispred;

    logic [RAS_PTR_W-1:0] w_tp_inc;
    logic [RAS_PTR_W-1:0] w_tp_dec;
    logic                 w_is_bclr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_popush;

    assign w_tp_inc  = r_tp + RAS_PTR_W'(1);
    assign w_tp_dec  = r_tp - RAS_PTR_W'(1);
    assign w_is_bclr = (Op == OP_BCLR);
    assign w_push    = w_upd & w_taken & w_lk & ~w_is_bclr;
    assign w_pop     = w_upd & w_taken & w_is_bclr & ~w_lk;
    assign w_popush  = w_upd & w_taken & w_is_bclr & w_lk;

    assign ras_pred       = r_ras[r_tp];
    assign ras_pred_valid = (r_cnt != '0);
    assign ras_count      = r_cnt;
    assign ras_mispred    = r_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp      <= '0;
            r_cnt     <= '0;
            r_mispred <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            // Only a taken BCLR against a live prediction can flag a miss.
            r_mispred <= w_upd & w_taken & w_is_bclr & ras_pred_valid & (ras_pred != NPC);

            // A pop+push on an empty stack degenerates to a plain push.
            if (w_push || (w_popush && !ras_pred_valid)) begin
                r_tp            <= w_tp_inc;
                r_ras[w_tp_inc] <= w_pcb4;
                if (r_cnt != CNT_FULL) begin
                    r_cnt <= r_cnt + (RAS_PTR_W+1)'(1);
                end
            end else if (w_popush) begin
                r_ras[r_tp] <= w_pcb4;
            end else if (w_pop && ras_pred_valid) begin
                r_tp  <= w_tp_dec;
                r_cnt <= r_cnt - (RAS_PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_npc_ras.sv
// ----------------------------------------------------------------------------
// tb_npc_ras
//
// Self-checking bench for npc_ras (default parameters). A directed vector
// table, hand-written multi-cycle sequences (overflow, underflow, mispredict,
// asynchronous reset, stall) and a randomized phase, all compared against a
// reference model: target arithmetic from the ISA field rules and a bounded
// queue standing in for the return-address stack (back = top of stack).
// ----------------------------------------------------------------------------
module tb_npc_ras;

    localparam int PW    = 32;
    localparam int DEPTH = 8;

    localparam logic [2:0] OP_PLUS4 = 3'd0;
    localparam logic [2:0] OP_B     = 3'd1;
    localparam logic [2:0] OP_BC    = 3'd2;
    localparam logic [2:0] OP_BCCTR = 3'd3;
    localparam logic [2:0] OP_BCLR  = 3'd4;
    localparam logic [2:0] OP_INT   = 3'd5;
    localparam logic [2:0] OP_RFI   = 3'd6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          op_valid, stall;
    logic [2:0]    Op;
    logic [25:0]   Imm26;
    logic [PW-1:0] PC, PCB, CTRrd, LRrd, SRR0rd;
    logic [31:0]   CRrd;
    logic [PW-1:0] NPC, CTRwd, LRwd, ras_pred;
    logic          ctr_we, lr_we, ras_pred_valid, ras_mispred;
    logic [3:0]    ras_count;

    npc_ras #(
        .PC_WIDTH (32),
        .RAS_DEPTH(8),
        .RAS_PTR_W(3),
        .INT_ENTRY(32'h0000_0500)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .stall         (stall),
        .Op            (Op),
        .Imm26         (Imm26),
        .PC            (PC),
        .PCB           (PCB),
        .CRrd          (CRrd),
        .CTRrd         (CTRrd),
        .LRrd          (LRrd),
        .SRR0rd        (SRR0rd),
        .NPC           (NPC),
        .CTRwd         (CTRwd),
        .ctr_we        (ctr_we),
        .LRwd          (LRwd),
        .lr_we         (lr_we),
        .ras_pred      (ras_pred),
        .ras_pred_valid(ras_pred_valid),
        .ras_mispred   (ras_mispred),
        .ras_count     (ras_count)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [PW-1:0] exp_q[$];
    bit            exp_mispred;
    bit            next_mispred;

    typedef struct {
        logic [31:0] npc;
        logic [31:0] ctrwd;
        logic [31:0] lrwd;
        bit          ctr_we;
        bit          lr_we;
        bit          taken;
        bit          lk;
        logic [2:0]  op;
        bit          upd;
    } exp_t;

    exp_t g_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the combinational resolve, from the ISA field rules.
    function automatic exp_t model(input bit v, input bit st, input logic [2:0] op,
                                   input logic [25:0] imm, input logic [31:0] pc_i,
                                   input logic [31:0] pcb_i, input logic [31:0] cr_i,
                                   input logic [31:0] ctr_i, input logic [31:0] lr_i,
                                   input logic [31:0] srr0_i);
        exp_t   e;
        int     bo [5];
        int     bi;
        longint li, bd, base;
        bit     ctr_ok, cond_ok, cr_bit;
        for (int k = 0; k < 5; k++) bo[k] = int'(imm[25-k]);
        bi   = int'(imm[20:16]);
        li   = longint'(imm[25:2]);
        if (li >= 64'sd8388608) li = li - 64'sd16777216;
        bd   = longint'(imm[15:2]);
        if (bd >= 64'sd8192) bd = bd - 64'sd16384;
        base = imm[1] ? 64'sd0 : longint'(pcb_i);
        e.lk    = imm[0];
        e.op    = op;
        e.upd   = v && !st;
        e.ctrwd = (bo[2] != 0) ? ctr_i : ctr_i - 32'd1;
        ctr_ok  = (bo[2] != 0) || ((e.ctrwd != 0) != (bo[3] != 0));
        cr_bit  = cr_i[31-bi];
        cond_ok = (bo[0] != 0) || (cr_bit == (bo[1] != 0));
        e.lrwd  = pcb_i + 32'd4;
        e.taken = 1'b0;
        e.npc   = pc_i + 32'd4;
        case (op)
            OP_B: begin
                e.taken = 1'b1;
                e.npc   = 32'(base + li * 4);
            end
            OP_BC: begin
                e.taken = ctr_ok && cond_ok;
                e.npc   = e.taken ? 32'(base + bd * 4) : e.lrwd;
            end
            OP_BCCTR: begin
                e.taken = cond_ok;
                e.npc   = e.taken ? (ctr_i & 32'hFFFF_FFFC) : e.lrwd;
            end
            OP_BCLR: begin
                e.taken = ctr_ok && cond_ok;
                e.npc   = e.taken ? (lr_i & 32'hFFFF_FFFC) : e.lrwd;
            end
            OP_INT:  e.npc = 32'h0000_0500;
            OP_RFI:  e.npc = srr0_i;
            default: e.npc = pc_i + 32'd4;
        endcase
        e.ctr_we = e.upd && (op == OP_BC || op == OP_BCLR) && (bo[2] == 0);
        e.lr_we  = e.upd && e.lk && (op >= OP_B && op <= OP_BCLR);
        return e;
    endfunction

    task automatic check_state(input string tag);
        check({tag, " ras_count"}, 32'(ras_count), 32'(exp_q.size()));
        check({tag, " ras_pred_valid"}, 32'(ras_pred_valid), 32'(exp_q.size() != 0));
        check({tag, " ras_mispred"}, 32'(ras_mispred), 32'(exp_mispred));
        if (exp_q.size() != 0)
            check({tag, " ras_pred"}, ras_pred, exp_q[exp_q.size()-1]);
    endtask

    // ---------------- driver tasks ----------------
    // Called shortly after a rising edge: applies inputs and checks the
    // combinational outputs before the next edge.
    task automatic drive(input bit v, input bit st, input logic [2:0] op,
                         input logic [25:0] imm, input logic [31:0] pc_i,
                         input logic [31:0] pcb_i, input logic [31:0] cr_i,
                         input logic [31:0] ctr_i, input logic [31:0] lr_i,
                         input logic [31:0] srr0_i, input string tag);
        op_valid = v;  stall = st;  Op = op;  Imm26 = imm;
        PC = pc_i;  PCB = pcb_i;  CRrd = cr_i;  CTRrd = ctr_i;  LRrd = lr_i;  SRR0rd = srr0_i;
        g_e = model(v, st, op, imm, pc_i, pcb_i, cr_i, ctr_i, lr_i, srr0_i);
        next_mispred = g_e.upd && g_e.taken && (op == OP_BCLR) && (exp_q.size() != 0) &&
                       (exp_q[exp_q.size()-1] != g_e.npc);
        #2;
        check({tag, " NPC"}, NPC, g_e.npc);
        check({tag, " CTRwd"}, CTRwd, g_e.ctrwd);
        check({tag, " LRwd"}, LRwd, g_e.lrwd);
        check({tag, " ctr_we"}, 32'(ctr_we), 32'(g_e.ctr_we));
        check({tag, " lr_we"}, 32'(lr_we), 32'(g_e.lr_we));
    endtask

    // Clocks the driven operation in, updates the stack model, checks state.
    task automatic step(input string tag);
        @(posedge clk);
        if (g_e.upd && g_e.taken) begin
            if (g_e.op != OP_BCLR && g_e.lk) begin
                exp_q.push_back(g_e.lrwd);
                if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            end else if (g_e.op == OP_BCLR && !g_e.lk) begin
                if (exp_q.size() != 0) void'(exp_q.pop_back());
            end else if (g_e.op == OP_BCLR && g_e.lk) begin
                if (exp_q.size() == 0) exp_q.push_back(g_e.lrwd);
                else exp_q[exp_q.size()-1] = g_e.lrwd;
            end
        end
        exp_mispred = next_mispred;
        #1;
        check_state(tag);
    endtask

    function automatic logic [25:0] imm_b(input logic [23:0] li, input bit aa, input bit lk);
        return {li, aa, lk};
    endfunction

    function automatic logic [25:0] imm_bc(input logic [4:0] bo, input logic [4:0] bi,
                                           input logic [13:0] bd, input bit aa, input bit lk);
        return {bo, bi, bd, aa, lk};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          v;
        logic [2:0]  op;
        logic [25:0] imm;
        logic [31:0] pc, pcb, cr, ctr, lr, srr0;
        logic [31:0] x_npc;
        bit          x_ctr_we, x_lr_we;
        int          x_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        string tag;
        logic [31:0] lr_v, exp_ret;

        // BO literals are written BO[0]..BO[4] left to right.
        tbl[0]  = '{1, OP_PLUS4, 26'd0,                              32'h100, 0,      0,            0,         0,     0,     32'h104,  0, 0, 0};
        tbl[1]  = '{1, OP_B,     imm_b(24'h10, 0, 1),                0,       32'h200, 0,           0,         0,     0,     32'h240,  0, 1, 1};
        tbl[2]  = '{1, OP_BC,    imm_bc(5'b00000, 0, 14'h8, 0, 0),   0,       32'h300, 0,           1,         0,     0,     32'h304,  1, 0, 1};
        tbl[3]  = '{1, OP_BC,    imm_bc(5'b00000, 0, 14'h8, 0, 0),   0,       32'h300, 0,           2,         0,     0,     32'h320,  1, 0, 1};
        tbl[4]  = '{1, OP_BC,    imm_bc(5'b00100, 0, 14'h3FFC, 0, 0),0,       32'h300, 0,           0,         0,     0,     32'h2F0,  0, 0, 1};
        tbl[5]  = '{1, OP_BCCTR, imm_bc(5'b10100, 0, 0, 0, 0),       0,       32'h300, 0,           32'h1237,  0,     0,     32'h1234, 0, 0, 1};
        tbl[6]  = '{1, OP_BCLR,  imm_bc(5'b10100, 0, 0, 0, 0),       0,       32'h300, 0,           0,         32'h204, 0,   32'h204,  0, 0, 0};
        tbl[7]  = '{1, OP_INT,   26'd0,                              32'h40,  0,      0,            0,         0,     0,     32'h500,  0, 0, 0};
        tbl[8]  = '{1, OP_RFI,   26'd0,                              32'h40,  0,      0,            0,         0,     32'hABC, 32'hABC, 0, 0, 0};
        tbl[9]  = '{1, 3'd7,     26'd0,                              32'h10,  0,      0,            0,         0,     0,     32'h14,   0, 0, 0};
        tbl[10] = '{1, OP_B,     imm_b(24'h1, 1, 0),                 0,       32'h800, 0,           0,         0,     0,     32'h4,    0, 0, 0};
        tbl[11] = '{1, OP_BC,    imm_bc(5'b00100, 5'd3, 14'h10, 0, 1),0,      32'h700, 32'h1000_0000, 0,      0,     0,     32'h704,  0, 1, 0};
        tbl[12] = '{0, OP_B,     imm_b(24'h4, 0, 1),                 0,       32'h900, 0,           0,         0,     0,     32'h910,  0, 0, 0};

        // Reset and its values
        rst_n = 1'b0;
        op_valid = 0; stall = 0; Op = OP_PLUS4; Imm26 = '0;
        PC = '0; PCB = '0; CRrd = '0; CTRrd = '0; LRrd = '0; SRR0rd = '0;
        exp_mispred = 0;
        g_e = model(0, 0, OP_PLUS4, '0, '0, '0, '0, '0, '0, '0);
        next_mispred = 0;
        #12;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table
        for (int i = 0; i < 13; i++) begin
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].v, 1'b0, tbl[i].op, tbl[i].imm, tbl[i].pc, tbl[i].pcb,
                  tbl[i].cr, tbl[i].ctr, tbl[i].lr, tbl[i].srr0, tag);
            check({tag, " tbl NPC"}, NPC, tbl[i].x_npc);
            check({tag, " tbl ctr_we"}, 32'(ctr_we), 32'(tbl[i].x_ctr_we));
            check({tag, " tbl lr_we"}, 32'(lr_we), 32'(tbl[i].x_lr_we));
            step(tag);
            check({tag, " tbl ras_count"}, 32'(ras_count), 32'(tbl[i].x_cnt));
        end
        check("tbl1 LRwd", 32'h204, 32'(tbl[1].pcb + 32'd4) == 32'h204 ? 32'h204 : 32'h0);

        // Overflow: nine pushes into an eight-entry stack
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, OP_B, imm_b(24'h4, 0, 1), 0, 32'h1000 + 32'(16 * i), 0, 0, 0, 0, "push");
            step("push");
        end
        check("overflow ras_count", 32'(ras_count), 32'd8);

        // Eight pops return newest-first; the oldest (0x1004) was overwritten
        for (int k = 0; k < 8; k++) begin
            exp_ret = 32'h1084 - 32'(16 * k);
            drive(1, 0, OP_BCLR, imm_bc(5'b10100, 0, 0, 0, 0), 0, 32'h3000, 0, 0, exp_ret, 0, "pop");
            check("pop ras_pred", ras_pred, exp_ret);
            check("pop NPC", NPC, exp_ret);
            step("pop");
        end
        drive(1, 0, OP_BCLR, imm_bc(5'b10100, 0, 0, 0, 0), 0, 32'h3000, 0, 0, 32'h2000, 0, "underflow");
        step("underflow");
        check("underflow ras_count", 32'(ras_count), 32'd0);
        check("underflow ras_mispred", 32'(ras_mispred), 32'd0);

        // Mispredict: push 0x304, return to 0x400
        drive(1, 0, OP_B, imm_b(24'h4, 0, 1), 0, 32'h300, 0, 0, 0, 0, "mp push");
        step("mp push");
        drive(1, 0, OP_BCLR, imm_bc(5'b10100, 0, 0, 0, 0), 0, 32'h500, 0, 0, 32'h400, 0, "mp pop");
        check("mp NPC", NPC, 32'h400);
        step("mp pop");
        check("mp flag set", 32'(ras_mispred), 32'd1);
        drive(1, 0, OP_PLUS4, 0, 32'h20, 0, 0, 0, 0, 0, "mp idle");
        step("mp idle");
        check("mp flag clear", 32'(ras_mispred), 32'd0);

        // Asynchronous reset with three live entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, OP_B, imm_b(24'h4, 0, 1), 0, 32'h2000 + 32'(16 * i), 0, 0, 0, 0, "pre-rst");
            step("pre-rst");
        end
        check("pre-rst ras_count", 32'(ras_count), 32'd3);
        drive(1, 0, OP_PLUS4, 0, 32'h40, 0, 0, 0, 0, 0, "rst");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_mispred = 0;
        next_mispred = 0;
        check("async rst ras_count", 32'(ras_count), 32'd0);
        check("async rst pred_valid", 32'(ras_pred_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post-rst");

        // Stall freezes the stack and suppresses LR write
        drive(1, 0, OP_B, imm_b(24'h4, 0, 1), 0, 32'h500, 0, 0, 0, 0, "pre-stall");
        step("pre-stall");
        drive(1, 1, OP_B, imm_b(24'h4, 0, 1), 0, 32'h600, 0, 0, 0, 0, "stall");
        check("stall lr_we", 32'(lr_we), 32'd0);
        step("stall");
        check("stall ras_count", 32'(ras_count), 32'd1);
        check("stall ras_pred", ras_pred, 32'h504);

        // Randomized phase against the model
        for (int n = 0; n < 600; n++) begin
            logic [2:0]  r_op;
            logic [25:0] r_imm;
            logic [31:0] r_pcb, r_ctr;
            r_op  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) r_op = 3'($urandom_range(1, 4));
            r_imm = 26'($urandom);
            r_pcb = $urandom & 32'hFFFF_FFFC;
            r_ctr = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            lr_v  = $urandom;
            if (exp_q.size() != 0 && $urandom_range(0, 1) != 0) lr_v = exp_q[exp_q.size()-1];
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), r_op, r_imm,
                  $urandom, r_pcb, $urandom, r_ctr, lr_v, $urandom, "rand");
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
